// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with a req/ready data-memory handshake.
// Define MULTICYCLE_CTRL_PERF_EN to build the retired-instruction and cycle counters.
module multicycle_ctrl (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic [2:0]  NPCOp,
    output logic [1:0]  EXTOp,
    output logic [1:0]  RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic        MemReq,
    output logic        MemWrite,
    output logic [1:0]  MemtoReg,
    output logic        Retire,
    output logic [31:0] InstrCount,
    output logic [31:0] CycleCount
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        K_NOP, K_ADD, K_SUB, K_JR, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_JAL
    } kind_t;

    state_t      state, next_state;
    kind_t       kind;
    logic [5:0]  op, funct;
    logic [1:0]  ext_exec, aluop_exec;
    logic        alusrc_exec;
    logic        unused_instr;

    assign op           = Instr[31:26];
    assign funct        = Instr[5:0];
    assign unused_instr = ^Instr[25:6];

    always_comb begin
        kind = K_NOP;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20:   kind = K_ADD;
                    6'h22:   kind = K_SUB;
                    6'h08:   kind = K_JR;
                    default: kind = K_NOP;
                endcase
            end
            6'h0d:   kind = K_ORI;
            6'h23:   kind = K_LW;
            6'h2b:   kind = K_SW;
            6'h04:   kind = K_BEQ;
            6'h0f:   kind = K_LUI;
            6'h03:   kind = K_JAL;
            default: kind = K_NOP;
        endcase
    end

    // ALU/extender setup chosen in EXEC and held through MEM or WB so operands stay stable.
    always_comb begin
        ext_exec    = 2'd0;
        alusrc_exec = 1'b0;
        aluop_exec  = 2'd0;
        case (kind)
            K_SUB: aluop_exec = 2'd1;
            K_BEQ: aluop_exec = 2'd1;
            K_ORI: begin alusrc_exec = 1'b1; aluop_exec = 2'd2; end
            K_LUI: begin ext_exec = 2'd2; alusrc_exec = 1'b1; aluop_exec = 2'd2; end
            K_LW, K_SW: begin ext_exec = 2'd1; alusrc_exec = 1'b1; end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        next_state = state;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        NPCOp      = 3'd0;
        EXTOp      = 2'd0;
        RegDst     = 2'd0;
        RegWrite   = 1'b0;
        ALUSrc     = 1'b0;
        ALUOp      = 2'd0;
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 2'd0;
        Retire     = 1'b0;
        // Gating on Reset drops every strobe, including a pending MemReq, the moment reset rises.
        if (!Reset) begin
            case (state)
                S_FETCH: begin
                    IRWrite    = 1'b1;
                    next_state = S_DECODE;
                end
                S_DECODE: begin
                    case (kind)
                        K_JAL: next_state = S_WB;
                        K_NOP: begin
                            PCWrite    = 1'b1;
                            Retire     = 1'b1;
                            next_state = S_FETCH;
                        end
                        default: next_state = S_EXEC;
                    endcase
                end
                S_EXEC: begin
                    EXTOp      = ext_exec;
                    ALUSrc     = alusrc_exec;
                    ALUOp      = aluop_exec;
                    next_state = S_FETCH;
                    case (kind)
                        K_ADD, K_SUB, K_ORI, K_LUI: next_state = S_WB;
                        K_LW, K_SW:                 next_state = S_MEM;
                        K_BEQ: begin
                            PCWrite = 1'b1;
                            NPCOp   = Zero ? 3'd1 : 3'd0;
                            Retire  = 1'b1;
                        end
                        K_JR: begin
                            PCWrite = 1'b1;
                            NPCOp   = 3'd3;
                            Retire  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    MemReq = 1'b1;
                    EXTOp  = ext_exec;
                    ALUSrc = alusrc_exec;
                    ALUOp  = aluop_exec;
                    case (kind)
                        K_SW: begin
                            MemWrite   = MemReady;
                            PCWrite    = MemReady;
                            Retire     = MemReady;
                            next_state = MemReady ? S_FETCH : S_MEM;
                        end
                        K_LW:    next_state = MemReady ? S_WB : S_MEM;
                        default: next_state = S_FETCH;
                    endcase
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    PCWrite    = 1'b1;
                    Retire     = 1'b1;
                    next_state = S_FETCH;
                    case (kind)
                        K_ADD, K_SUB: begin
                            RegDst = 2'd1;
                            EXTOp  = ext_exec;
                            ALUSrc = alusrc_exec;
                            ALUOp  = aluop_exec;
                        end
                        K_ORI, K_LUI: begin
                            EXTOp  = ext_exec;
                            ALUSrc = alusrc_exec;
                            ALUOp  = aluop_exec;
                        end
                        K_LW:  MemtoReg = 2'd1;
                        K_JAL: begin
                            RegDst   = 2'd2;
                            MemtoReg = 2'd2;
                            NPCOp    = 3'd2;
                        end
                        default: ;
                    endcase
                end
                default: next_state = S_FETCH;
            endcase
        end
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instr_cnt, cycle_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            instr_cnt <= 32'd0;
            cycle_cnt <= 32'd0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (Retire) instr_cnt <= instr_cnt + 32'd1;
        end
    end

    assign InstrCount = instr_cnt;
    assign CycleCount = cycle_cnt;
`else
    assign InstrCount = 32'd0;
    assign CycleCount = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control words are queued per instruction
// and compared against the DUT on each falling clock edge.
module tb_multicycle_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Zero, MemReady;
    logic [31:0] Instr;
    logic        IRWrite, PCWrite, RegWrite, ALUSrc, MemReq, MemWrite, Retire;
    logic [2:0]  NPCOp;
    logic [1:0]  EXTOp, RegDst, ALUOp, MemtoReg;
    logic [31:0] InstrCount, CycleCount;

    multicycle_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .Zero(Zero), .MemReady(MemReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .NPCOp(NPCOp), .EXTOp(EXTOp),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .MemReq(MemReq), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .Retire(Retire),
        .InstrCount(InstrCount), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic [2:0] npc;
        logic [1:0] ext;
        logic [1:0] regdst;
        logic       regw;
        logic       alusrc;
        logic [1:0] aluop;
        logic       memreq;
        logic       memw;
        logic [1:0] m2r;
        logic       retire;
    } ctrl_t;

    typedef struct packed {
        logic  ready;
        ctrl_t exp;
    } step_t;

    typedef enum {T_NOP, T_ADD, T_SUB, T_JR, T_ORI, T_LW, T_SW, T_BEQ, T_LUI, T_JAL} tkind_t;

`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam logic [31:0] EXP_ICNT = 32'd10;
    localparam logic [31:0] EXP_CCNT = 32'd40;
`else
    localparam logic [31:0] EXP_ICNT = 32'd0;
    localparam logic [31:0] EXP_CCNT = 32'd0;
`endif

    step_t sb_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    logic  idle_rdy = 1'b0;

    function automatic ctrl_t actual();
        ctrl_t a;
        a.irw = IRWrite;   a.pcw = PCWrite;   a.npc = NPCOp;     a.ext = EXTOp;
        a.regdst = RegDst; a.regw = RegWrite; a.alusrc = ALUSrc; a.aluop = ALUOp;
        a.memreq = MemReq; a.memw = MemWrite; a.m2r = MemtoReg;  a.retire = Retire;
        return a;
    endfunction

    task automatic push(input logic rdy, input ctrl_t c);
        step_t s;
        s.ready = rdy;
        s.exp   = c;
        sb_q.push_back(s);
    endtask

    // Expected control words per cycle, written straight from the instruction timing tables.
    task automatic queue_instr(input tkind_t k, input logic z, input int w);
        ctrl_t c;
        c = '0; c.irw = 1'b1;
        push(idle_rdy, c);
        c = '0;
        if (k == T_NOP) begin
            c.pcw = 1'b1; c.retire = 1'b1;
            push(idle_rdy, c);
            return;
        end
        push(idle_rdy, c);
        if (k == T_JAL) begin
            c.regw = 1'b1; c.pcw = 1'b1; c.retire = 1'b1;
            c.regdst = 2'd2; c.m2r = 2'd2; c.npc = 3'd2;
            push(idle_rdy, c);
            return;
        end
        case (k)
            T_SUB: c.aluop = 2'd1;
            T_ORI: begin c.alusrc = 1'b1; c.aluop = 2'd2; end
            T_LUI: begin c.ext = 2'd2; c.alusrc = 1'b1; c.aluop = 2'd2; end
            T_LW, T_SW: begin c.ext = 2'd1; c.alusrc = 1'b1; end
            T_BEQ: begin
                c.aluop = 2'd1; c.pcw = 1'b1; c.retire = 1'b1;
                c.npc = z ? 3'd1 : 3'd0;
            end
            T_JR: begin c.pcw = 1'b1; c.npc = 3'd3; c.retire = 1'b1; end
            default: ;
        endcase
        push(idle_rdy, c);
        if (k == T_BEQ || k == T_JR) return;
        if (k == T_LW || k == T_SW) begin
            c.memreq = 1'b1;
            repeat (w) push(1'b0, c);
            if (k == T_SW) begin
                c.memw = 1'b1; c.pcw = 1'b1; c.retire = 1'b1;
                push(1'b1, c);
                return;
            end
            push(1'b1, c);
            c = '0;
            c.regw = 1'b1; c.pcw = 1'b1; c.retire = 1'b1; c.m2r = 2'd1;
            push(idle_rdy, c);
            return;
        end
        c.regw = 1'b1; c.pcw = 1'b1; c.retire = 1'b1;
        if (k == T_ADD || k == T_SUB) c.regdst = 2'd1;
        push(idle_rdy, c);
    endtask

    // Entered #1 after a rising edge; leaves #1 after the rising edge ending the last queued cycle.
    task automatic drain(input string name);
        step_t s;
        ctrl_t a;
        int    idx = 0;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            MemReady = s.ready;
            @(negedge Clk);
            a = actual();
            n_checks++;
            if (a !== s.exp)
                $display("FAIL %s step %0d: got %h expected %h", name, idx, a, s.exp);
            else
                n_pass++;
            @(posedge Clk);
            #1;
            idx++;
        end
    endtask

    task automatic run(input string name, input logic [31:0] ins, input tkind_t k,
                       input logic z, input int w);
        Instr = ins;
        Zero  = z;
        queue_instr(k, z, w);
        drain(name);
    endtask

    task automatic test_reset();
        Reset = 1'b1; Instr = 32'h8C09_0000; Zero = 1'b1; MemReady = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if (actual() !== ctrl_t'('0)) $display("FAIL reset_outputs: got %h expected 0", actual());
        else n_pass++;
        n_checks++;
        if (InstrCount !== 32'd0 || CycleCount !== 32'd0)
            $display("FAIL reset_counters: got %h/%h expected 0/0", InstrCount, CycleCount);
        else n_pass++;
        @(posedge Clk);
        #1;
        Reset = 1'b0; MemReady = 1'b0; Zero = 1'b0;
    endtask

    task automatic test_alu();
        run("ori", 32'h3408_0005, T_ORI, 1'b0, 0);
        idle_rdy = 1'b1;
        run("add", 32'h012A_4020, T_ADD, 1'b0, 0);
        run("sub", 32'h012A_4022, T_SUB, 1'b1, 0);
        run("lui", 32'h3C08_1234, T_LUI, 1'b0, 0);
        idle_rdy = 1'b0;
    endtask

    task automatic test_mem();
        run("lw_w3", 32'h8C09_0000, T_LW, 1'b0, 3);
        run("lw_w0", 32'h8C09_0008, T_LW, 1'b0, 0);
        run("sw_w0", 32'hAC09_0004, T_SW, 1'b0, 0);
        run("sw_w2", 32'hAC09_0004, T_SW, 1'b0, 2);
    endtask

    task automatic test_branch_jump();
        run("beq_taken", 32'h1109_0003, T_BEQ, 1'b1, 0);
        run("beq_not",   32'h1109_0003, T_BEQ, 1'b0, 0);
        run("jal",       32'h0C00_0010, T_JAL, 1'b0, 0);
        run("jr",        32'h03E0_0008, T_JR,  1'b0, 0);
    endtask

    task automatic test_back_to_back();
        idle_rdy = 1'b1;
        run("nop_zero",  32'h0000_0000, T_NOP, 1'b0, 0);
        run("unknown",   32'hFC00_0000, T_NOP, 1'b0, 0);
        run("bad_funct", 32'h012A_4021, T_NOP, 1'b1, 0);
        run("add_b2b",   32'h012A_4020, T_ADD, 1'b0, 0);
        run("jal_b2b",   32'h0C00_0020, T_JAL, 1'b0, 0);
        idle_rdy = 1'b0;
    endtask

    task automatic test_mem_reset_abort();
        ctrl_t c;
        Instr = 32'hAC09_0004; Zero = 1'b0;
        c = '0; c.irw = 1'b1;        push(1'b0, c);
        c = '0;                      push(1'b0, c);
        c.ext = 2'd1; c.alusrc = 1'b1; push(1'b0, c);
        c.memreq = 1'b1;             push(1'b0, c);
        drain("abort_pre");
        MemReady = 1'b0;
        n_checks++;
        if (MemReq !== 1'b1) $display("FAIL abort_memreq_before: got %b expected 1", MemReq);
        else n_pass++;
        Reset = 1'b1;
        #1;
        n_checks++;
        if (actual() !== ctrl_t'('0)) $display("FAIL abort_async_drop: got %h expected 0", actual());
        else n_pass++;
        MemReady = 1'b1;
        @(posedge Clk);
        #1;
        n_checks++;
        if (MemWrite !== 1'b0 || PCWrite !== 1'b0 || RegWrite !== 1'b0)
            $display("FAIL abort_no_write: got %b%b%b expected 000", MemWrite, PCWrite, RegWrite);
        else n_pass++;
        n_checks++;
        if (InstrCount !== 32'd0 || CycleCount !== 32'd0)
            $display("FAIL abort_counters: got %h/%h expected 0/0", InstrCount, CycleCount);
        else n_pass++;
        Reset = 1'b0;
        MemReady = 1'b0;
        run("after_abort", 32'h3408_0005, T_ORI, 1'b0, 0);
    endtask

    task automatic test_perf();
        Reset = 1'b1;
        #2;
        n_checks++;
        if (InstrCount !== 32'd0 || CycleCount !== 32'd0)
            $display("FAIL perf_reset: got %h/%h expected 0/0", InstrCount, CycleCount);
        else n_pass++;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) run("perf_ori", 32'h3408_0005, T_ORI, 1'b0, 0);
        n_checks++;
        if (InstrCount !== EXP_ICNT) $display("FAIL perf_instr: got %0d expected %0d", InstrCount, EXP_ICNT);
        else n_pass++;
        n_checks++;
        if (CycleCount !== EXP_CCNT) $display("FAIL perf_cycle: got %0d expected %0d", CycleCount, EXP_CCNT);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch_jump();
        test_back_to_back();
        test_mem_reset_abort();
        test_perf();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
